// File: rtl/urand_pair_fp.sv
// urand_pair_fp: converts 64-bit uniform words to (0,1) doubles and pairs them into (a, b).
// Build option: define URAND_ZERO_REJECT_EN to drop all-zero words at the input stage.
module urand_pair_fp (
  input  logic        clk,
  input  logic        rst,
  input  logic        pushin,
  input  logic [63:0] rnd,
  output logic        pushout,
  output logic [63:0] a,
  output logic [63:0] b,
  output logic [31:0] pairs
);
  localparam int BIAS = 1023;
  localparam logic [10:0] EXP_TOP  = 11'(BIAS - 1);
  localparam logic [10:0] EXP_ZERO = 11'(BIAS - 65);

  typedef enum logic {HALF0 = 1'b0, HALF1 = 1'b1} phase_t;

  // ---------------- S1: input register ----------------
  logic        word_ok;
  logic        s1_valid;
  logic [63:0] s1_word;

`ifdef URAND_ZERO_REJECT_EN
  assign word_ok = pushin && (rnd != '0);
`else
  assign word_ok = pushin;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_word  <= '0;
    end else begin
      s1_valid <= word_ok;
      s1_word  <= rnd;
    end
  end

  // ---------------- S2: leading-zero count and normalise ----------------
  logic [63:0] norm;
  logic [5:0]  lz;
  logic [10:0] unused_lsbs;

  always_comb begin
    lz   = '0;
    norm = s1_word;
    if (norm[63:32] == '0) begin lz[5] = 1'b1; norm = norm << 32; end
    if (norm[63:48] == '0) begin lz[4] = 1'b1; norm = norm << 16; end
    if (norm[63:56] == '0) begin lz[3] = 1'b1; norm = norm << 8;  end
    if (norm[63:60] == '0) begin lz[2] = 1'b1; norm = norm << 4;  end
    if (norm[63:62] == '0) begin lz[1] = 1'b1; norm = norm << 2;  end
    if (norm[63]    == 1'b0) begin lz[0] = 1'b1; norm = norm << 1; end
  end

  // Bits below the 52-bit fraction are truncated, never rounded.
  assign unused_lsbs = norm[10:0];

  logic        s2_valid;
  logic        s2_zero;
  logic [5:0]  s2_lz;
  logic [51:0] s2_mant;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s2_valid <= 1'b0;
      s2_zero  <= 1'b0;
      s2_lz    <= '0;
      s2_mant  <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_zero  <= ~norm[63];
      s2_lz    <= lz;
      s2_mant  <= norm[62:11];
    end
  end

  // ---------------- S3: pack fields ----------------
  logic [10:0] exp_field;
  logic        s3_valid;
  logic [63:0] s3_value;

  assign exp_field = s2_zero ? EXP_ZERO : (EXP_TOP - {5'd0, s2_lz});

  always_ff @(posedge clk) begin
    if (!rst) begin
      s3_valid <= 1'b0;
      s3_value <= '0;
    end else begin
      s3_valid <= s2_valid;
      s3_value <= {1'b0, exp_field, s2_mant};
    end
  end

  // ---------------- Pairing ----------------
  phase_t      phase;
  logic [63:0] hold;
  logic [31:0] pair_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      phase    <= HALF0;
      hold     <= '0;
      a        <= '0;
      b        <= '0;
      pushout  <= 1'b0;
      pair_cnt <= '0;
    end else begin
      pushout <= 1'b0;
      if (s3_valid) begin
        if (phase == HALF0) begin
          hold  <= s3_value;
          phase <= HALF1;
        end else begin
          a        <= hold;
          b        <= s3_value;
          pushout  <= 1'b1;
          pair_cnt <= pair_cnt + 32'd1;
          phase    <= HALF0;
        end
      end
    end
  end

  assign pairs = pair_cnt;
endmodule

// File: tb/tb_urand_pair_fp.sv
// Bench for urand_pair_fp: edge-level delay-queue model plus directed and random streams.
module tb_urand_pair_fp;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pushin = 1'b0;
  logic [63:0] rnd = '0;
  logic        pushout;
  logic [63:0] a;
  logic [63:0] b;
  logic [31:0] pairs;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  urand_pair_fp dut (
    .clk(clk), .rst(rst), .pushin(pushin), .rnd(rnd),
    .pushout(pushout), .a(a), .b(b), .pairs(pairs)
  );

  // Value of 0.w as a double: find the leading one, take the 52 bits below it.
  function automatic logic [63:0] conv(input logic [63:0] w);
    int p;
    logic [63:0] f;
    if (w == 64'd0) return {1'b0, 11'd958, 52'd0};
    p = 63;
    while (!w[p]) p--;
    f = w << (64 - p);
    return {1'b0, 11'(1022 - (63 - p)), f[63:12]};
  endfunction

  function automatic bit accept(input logic [63:0] w);
`ifdef URAND_ZERO_REJECT_EN
    return w != 64'd0;
`else
    return (w == w);
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, got, want);
    end
  endtask

  // Model: each accepted word becomes visible 3 edges after it is sampled.
  int          edge_n = 0;
  bit          live = 1'b0;
  int          due_q[$];
  logic [63:0] val_q[$];
  bit          have_half = 1'b0;
  logic [63:0] half = '0;
  logic        exp_po = 1'b0;
  logic [63:0] exp_a = '0;
  logic [63:0] exp_b = '0;
  logic [31:0] exp_cnt = '0;
  int          po_seen = 0;

  always @(posedge clk) begin
    logic [63:0] v;
    edge_n++;
    if (!rst) begin
      live = 1'b1;
      due_q.delete();
      val_q.delete();
      have_half = 1'b0;
      exp_po = 1'b0;
      exp_a = '0;
      exp_b = '0;
      exp_cnt = '0;
    end else begin
      exp_po = 1'b0;
      if (due_q.size() > 0 && due_q[0] == edge_n) begin
        void'(due_q.pop_front());
        v = val_q.pop_front();
        if (have_half) begin
          exp_a = half;
          exp_b = v;
          exp_po = 1'b1;
          exp_cnt = exp_cnt + 32'd1;
          have_half = 1'b0;
        end else begin
          half = v;
          have_half = 1'b1;
        end
      end
      if (pushin && accept(rnd)) begin
        due_q.push_back(edge_n + 3);
        val_q.push_back(conv(rnd));
      end
    end
  end

  always @(negedge clk) begin
    if (live) begin
      check("pushout", {63'd0, pushout}, {63'd0, exp_po});
      check("a", a, exp_a);
      check("b", b, exp_b);
      check("pairs", {32'd0, pairs}, {32'd0, exp_cnt});
      if (pushout === 1'b1) begin
        po_seen++;
        $display("pair pairs=%08h a=%016h b=%016h", pairs, a, b);
      end
    end
  end

  task automatic step(input bit p, input logic [63:0] w);
    pushin = p;
    rnd = w;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 64'd0);
  endtask

  function automatic logic [63:0] rand_word();
    logic [63:0] w;
    w = {$urandom, $urandom} >> $urandom_range(0, 63);
    if (w == 64'd0) w = 64'd1;
    return w;
  endfunction

  initial begin
    logic [63:0] w0, w1, w2;

    check("pin_half", conv(64'h8000_0000_0000_0000), 64'h3FE0_0000_0000_0000);
    check("pin_ones", conv(64'hFFFF_FFFF_FFFF_FFFF), 64'h3FEF_FFFF_FFFF_FFFF);
    check("pin_one",  conv(64'h0000_0000_0000_0001), 64'h3BF0_0000_0000_0000);
    check("pin_zero", conv(64'd0), 64'h3BE0_0000_0000_0000);
    check("pin_three", conv(64'h0000_0000_0000_0003), 64'h3C08_0000_0000_0000);

    rst = 1'b0;
    pushin = 1'b1;
    rnd = 64'h1234;
    repeat (3) @(negedge clk);
    check("rst_pushout", {63'd0, pushout}, 64'd0);
    check("rst_a", a, 64'd0);
    check("rst_b", b, 64'd0);
    check("rst_pairs", {32'd0, pairs}, 64'd0);
    rst = 1'b1;

    // Pair and latency
    step(1'b1, 64'h8000_0000_0000_0000);
    step(1'b1, 64'h4000_0000_0000_0000);
    idle(2);
    check("lat_early", {63'd0, pushout}, 64'd0);
    idle(1);
    check("lat_hit", {63'd0, pushout}, 64'd1);
    check("lat_a", a, 64'h3FE0_0000_0000_0000);
    check("lat_b", b, 64'h3FD0_0000_0000_0000);
    check("lat_pairs", {32'd0, pairs}, 64'd1);
    idle(1);
    check("lat_single", {63'd0, pushout}, 64'd0);

    // Extremes
    step(1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    step(1'b1, 64'h0000_0000_0000_0001);
    idle(4);
    check("ext_a", a, 64'h3FEF_FFFF_FFFF_FFFF);
    check("ext_b", b, 64'h3BF0_0000_0000_0000);

    // Zero word
`ifdef URAND_ZERO_REJECT_EN
    step(1'b1, 64'd0);
    step(1'b1, 64'h8000_0000_0000_0000);
    step(1'b1, 64'h4000_0000_0000_0000);
    idle(4);
    check("zr_a", a, 64'h3FE0_0000_0000_0000);
    check("zr_b", b, 64'h3FD0_0000_0000_0000);
    check("zr_pairs", {32'd0, pairs}, 64'd3);
`else
    step(1'b1, 64'd0);
    step(1'b1, 64'h0000_0000_0000_0003);
    idle(4);
    check("zero_a", a, 64'h3BE0_0000_0000_0000);
    check("zero_b", b, 64'h3C08_0000_0000_0000);
`endif

    // Gapped pair
    w0 = rand_word();
    w1 = rand_word();
    step(1'b1, w0);
    idle(5);
    step(1'b1, w1);
    idle(2);
    check("gap_early", {63'd0, pushout}, 64'd0);
    idle(1);
    check("gap_hit", {63'd0, pushout}, 64'd1);
    check("gap_a", a, conv(w0));
    check("gap_b", b, conv(w1));

    // 100 back-to-back random words
    idle(2);
    po_seen = 0;
    for (int i = 0; i < 100; i++) step(1'b1, rand_word());
    idle(5);
    check("stream_pairs", 64'(po_seen), 64'd50);

    // Random gaps
    for (int i = 0; i < 80; i++) step(1'($urandom_range(0, 1)), rand_word());
    idle(4);

    // Reset mid-pair
    w0 = rand_word();
    w1 = rand_word();
    w2 = rand_word();
    step(1'b1, w0);
    step(1'b0, 64'd0);
    rst = 1'b0;
    pushin = 1'b1;
    rnd = rand_word();
    @(negedge clk);
    check("mid_rst_pushout", {63'd0, pushout}, 64'd0);
    check("mid_rst_a", a, 64'd0);
    check("mid_rst_b", b, 64'd0);
    check("mid_rst_pairs", {32'd0, pairs}, 64'd0);
    rst = 1'b1;
    po_seen = 0;
    step(1'b1, w1);
    step(1'b1, w2);
    idle(5);
    check("mid_rst_count", 64'(po_seen), 64'd1);
    check("mid_rst_pa", a, conv(w1));
    check("mid_rst_pb", b, conv(w2));

    // Counter wrap
    #2;
    force dut.pair_cnt = 32'hFFFF_FFFE;
    exp_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.pair_cnt;
    @(negedge clk);
    step(1'b1, rand_word());
    step(1'b1, rand_word());
    idle(4);
    check("wrap_max", {32'd0, pairs}, 64'h0000_0000_FFFF_FFFF);
    step(1'b1, rand_word());
    step(1'b1, rand_word());
    idle(4);
    check("wrap_zero", {32'd0, pairs}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
